// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// bit positions of the sticky error flags.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } arb_state_t;

    localparam int UART_ARB_STATES_NUM = 4;

    // err[ERR_START]: uart_tx never raised busy; err[ERR_GAP]: requester stalled mid-packet
    localparam int ERR_START = 0;
    localparam int ERR_GAP   = 1;
    localparam int ERR_W     = 2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: returns the first asserted request
// strictly after ptr (cyclic), as one-hot, as an index, and an any flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                            = 1'b1;
                idx                            = IW'((int'(ptr) + k) % N);
                onehot[(int'(ptr) + k) % N]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ byte
// streams, with start and inter-byte watchdogs and sticky error flags.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 tx_pause,
    output logic                 tx_write,
    output logic [7:0]           tx_byte,
    input  logic                 tx_busy,
    output logic [ERR_W-1:0]     err,
    input  logic                 err_clear
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    arb_state_t           state_reg;
    logic [NUM_REQ-1:0]   grant_reg;
    logic [IW-1:0]        gidx_reg;
    logic [IW-1:0]        rr_ptr_reg;
    logic [TW-1:0]        timer_reg;
    logic                 busy_q_reg;
    logic                 last_q_reg;
    logic                 tx_write_reg;
    logic [7:0]           tx_byte_reg;
    logic [ERR_W-1:0]     err_reg;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 fire;
    logic                 busy_fall;
    logic                 timer_expired;
    logic [7:0]           cur_data;
    logic                 cur_last;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Only the owner may hand over a byte, and never while paused or while uart_tx is busy
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == ST_LOAD) & grant_reg[gi] & ~tx_pause & ~tx_busy;
        end
    endgenerate

    assign fire          = |(req_ready & req_valid);
    assign busy_fall     = busy_q_reg & ~tx_busy;
    assign timer_expired = (timer_reg == T_LAST);
    assign cur_data      = req_data[{gidx_reg, 3'b000} +: 8];
    assign cur_last      = req_last[gidx_reg];

    assign grant    = grant_reg;
    assign tx_write = tx_write_reg;
    assign tx_byte  = tx_byte_reg;
    assign err      = err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            gidx_reg     <= '0;
            rr_ptr_reg   <= PTR_RST;
            timer_reg    <= '0;
            busy_q_reg   <= 1'b0;
            last_q_reg   <= 1'b0;
            tx_write_reg <= 1'b0;
            tx_byte_reg  <= '0;
            err_reg      <= '0;
        end else begin
            busy_q_reg <= tx_busy;
            // Set events below are later assignments, so they override a clear
            if (err_clear) begin
                err_reg <= '0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!tx_busy && !tx_pause && pick_any) begin
                        grant_reg <= pick_onehot;
                        gidx_reg  <= pick_idx;
                        timer_reg <= '0;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (fire) begin
                        tx_byte_reg  <= cur_data;
                        tx_write_reg <= 1'b1;
                        last_q_reg   <= cur_last;
                        timer_reg    <= '0;
                        state_reg    <= ST_WAIT_START;
                    end else if (!tx_pause) begin
                        if (timer_expired) begin
                            err_reg[ERR_GAP] <= 1'b1;
                            grant_reg        <= '0;
                            rr_ptr_reg       <= gidx_reg;
                            timer_reg        <= '0;
                            state_reg        <= ST_IDLE;
                        end else begin
                            timer_reg <= timer_reg + TW'(1);
                        end
                    end
                end
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        tx_write_reg <= 1'b0;
                        state_reg    <= ST_WAIT_DONE;
                    end else if (timer_expired) begin
                        tx_write_reg       <= 1'b0;
                        err_reg[ERR_START] <= 1'b1;
                        grant_reg          <= '0;
                        rr_ptr_reg         <= gidx_reg;
                        timer_reg          <= '0;
                        state_reg          <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (busy_fall) begin
                        if (last_q_reg) begin
                            grant_reg  <= '0;
                            rr_ptr_reg <= gidx_reg;
                            state_reg  <= ST_IDLE;
                        end else begin
                            timer_reg <= '0;
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte FIFOs, a uart_tx busy model, and a
// scoreboard of expected (requester, byte) pairs checked at each tx_write.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BUSY_CYC = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_pause;
    logic           tx_write;
    logic [7:0]     tx_byte;
    logic           tx_busy;
    logic [1:0]     err;
    logic           err_clear;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_pause  (tx_pause),
        .tx_write  (tx_write),
        .tx_byte   (tx_byte),
        .tx_busy   (tx_busy),
        .err       (err),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    // Requester byte streams: ring buffers, head advanced on valid&ready
    logic [7:0] rq_data [N][256];
    logic       rq_last [N][256];
    logic [7:0] rq_pos  [N] = '{default: 8'd0};
    logic [7:0] rq_end  [N] = '{default: 8'd0};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (rq_pos[i] != rq_end[i]);
            req_data[8*i +: 8] = rq_data[i][rq_pos[i]];
            req_last[i]        = rq_last[i][rq_pos[i]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) rq_pos[i] <= rq_pos[i] + 8'd1;
        end
    end

    // uart_tx model: latches a byte when idle and write is high, busy for BUSY_CYC cycles
    logic busy_m   = 1'b0;
    int   bcnt     = 0;
    logic model_en = 1'b1;

    always @(posedge clk) begin
        if (busy_m) begin
            if (bcnt == 1) busy_m <= 1'b0;
            bcnt <= bcnt - 1;
        end else if (model_en && tx_write) begin
            busy_m <= 1'b1;
            bcnt   <= BUSY_CYC;
        end
    end
    assign tx_busy = busy_m;

    typedef struct {
        int         r;
        logic [7:0] b;
    } sb_t;
    sb_t sbq[$];

    always @(negedge clk) begin
        if (model_en && tx_write && !busy_m) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_write: got byte %0h grant %b, expected none", tx_byte, grant);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("sb_byte", 32'(tx_byte), 32'(e.b));
                check("sb_grant", 32'(grant), 32'(1) << e.r);
            end
        end
    end

    task automatic load_pkt(input int r, input int len, input logic [7:0] base, input bit push);
        for (int k = 0; k < len; k++) begin
            rq_data[r][rq_end[r]] = base + 8'(k);
            rq_last[r][rq_end[r]] = (k == len - 1);
            if (push) sbq.push_back('{r: r, b: base + 8'(k)});
            rq_end[r] = rq_end[r] + 8'd1;
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (sbq.size() == 0 && grant == '0 && !busy_m && !tx_write) done = 1;
        end
        if (!done) check({name, "_drain_timeout"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic wait_busy(input logic level, input string name);
        bit done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (busy_m == level) done = 1;
        end
        if (!done) check({name, "_busy_timeout"}, 32'(busy_m), 32'(level));
    endtask

    function automatic logic [7:0] bval(input int v, input int r, input int k);
        return {v[3:0], r[1:0], k[1:0]};
    endfunction

    typedef struct {
        logic [3:0] mask;
        int         len;
        int         n;
        logic [7:0] order;   // 2-bit requester indices, entry 0 in LSBs
    } vec_t;
    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        int viol;
        bit seen;

        // Simultaneous packets; expected grant order follows rr_ptr carried from the previous row
        vecs[0] = '{mask: 4'b1111, len: 2, n: 4, order: 8'b11_10_01_00};
        vecs[1] = '{mask: 4'b1010, len: 1, n: 2, order: 8'b00_00_11_01};
        vecs[2] = '{mask: 4'b0101, len: 1, n: 2, order: 8'b00_00_10_00};
        vecs[3] = '{mask: 4'b1001, len: 1, n: 2, order: 8'b00_00_00_11};
        vecs[4] = '{mask: 4'b0110, len: 3, n: 2, order: 8'b00_00_10_01};
        vecs[5] = '{mask: 4'b0001, len: 1, n: 1, order: 8'b00_00_00_00};

        reset     = 1'b1;
        tx_pause  = 1'b0;
        err_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_write", 32'(tx_write), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) begin
                if (vecs[v].mask[i]) load_pkt(i, vecs[v].len, bval(v, i, 0), 1'b0);
            end
            for (int j = 0; j < vecs[v].n; j++) begin
                logic [7:0] ord;
                int r;
                ord = vecs[v].order;
                r   = int'(ord[2*j +: 2]);
                for (int k = 0; k < vecs[v].len; k++) sbq.push_back('{r: r, b: bval(v, r, k)});
            end
            wait_drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_err", v), 32'(err), 32'd0);
        end

        // Three-byte packet on requester 2
        load_pkt(2, 1, 8'hA1, 1'b1);
        load_pkt(2, 1, 8'hA2, 1'b1);
        load_pkt(2, 1, 8'hA3, 1'b1);
        rq_last[2][rq_end[2] - 8'd2] = 1'b0;
        rq_last[2][rq_end[2] - 8'd3] = 1'b0;
        @(negedge clk);
        cnt  = 0;
        viol = 0;
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            logic prev;
            prev = busy_m;
            if (grant != 4'b0100) viol++;
            @(negedge clk);
            if (prev && !busy_m) begin
                cnt++;
                if (cnt == 3) seen = 1;
            end
        end
        check("a_grant_held_violations", 32'(viol), 32'd0);
        check("a_third_fall_seen", 32'(seen), 32'd1);
        check("a_grant_at_fall", 32'(grant), 32'b0100);
        @(negedge clk);
        check("a_grant_drop", 32'(grant), 32'd0);
        wait_drain("a");

        // Pause during WAIT_DONE of byte 1 of 2
        load_pkt(1, 2, 8'hB1, 1'b1);
        wait_busy(1'b1, "pause_start");
        tx_pause = 1'b1;
        wait_busy(1'b0, "pause_end");
        viol = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (req_ready != '0 || tx_write) viol++;
        end
        check("pause_ready_violations", 32'(viol), 32'd0);
        check("pause_sb_pending", 32'(sbq.size()), 32'd1);
        check("pause_err", 32'(err), 32'd0);
        tx_pause = 1'b0;
        wait_drain("pause");
        check("pause_err_after", 32'(err), 32'd0);

        // uart_tx never raises busy: start timeout
        model_en = 1'b0;
        load_pkt(0, 1, 8'hC1, 1'b0);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx_write) seen = 1;
        end
        check("st_write_seen", 32'(seen), 32'd1);
        cnt = 0;
        for (int c = 0; c < 200 && !err[0]; c++) begin
            @(negedge clk);
            cnt++;
        end
        check("st_cycles_to_err", 32'(cnt), 32'd64);
        check("st_err", 32'(err), 32'b01);
        check("st_tx_write", 32'(tx_write), 32'd0);
        check("st_grant", 32'(grant), 32'd0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("st_err_cleared", 32'(err), 32'd0);
        model_en = 1'b1;

        // Requester 3 withholds its second byte: gap timeout, then requester 0 served
        load_pkt(3, 1, 8'hD1, 1'b1);
        rq_last[3][rq_end[3] - 8'd1] = 1'b0;
        load_pkt(0, 1, 8'hE1, 1'b1);
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[3] && sbq.size() == 1) seen = 1;
        end
        check("gap_reload_seen", 32'(seen), 32'd1);
        cnt = 1;
        for (int c = 0; c < 200 && !err[1]; c++) begin
            @(negedge clk);
            if (req_ready[3]) cnt++;
        end
        check("gap_ready_cycles", 32'(cnt), 32'd64);
        check("gap_err", 32'(err), 32'b10);
        check("gap_grant_drop", 32'(grant), 32'd0);
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (grant != '0) seen = 1;
        end
        check("gap_next_grant", 32'(grant), 32'b0001);
        wait_drain("gap");
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("gap_err_cleared", 32'(err), 32'd0);

        // Reset while uart_tx is mid-byte
        load_pkt(2, 2, 8'hF1, 1'b0);
        sbq.push_back('{r: 2, b: 8'hF1});
        wait_busy(1'b1, "rst_mid");
        reset = 1'b1;
        rq_end[2] = rq_pos[2];
        @(negedge clk);
        check("rmid_grant", 32'(grant), 32'd0);
        check("rmid_req_ready", 32'(req_ready), 32'd0);
        check("rmid_tx_write", 32'(tx_write), 32'd0);
        check("rmid_tx_byte", 32'(tx_byte), 32'd0);
        load_pkt(1, 1, 8'h61, 1'b0);
        load_pkt(0, 1, 8'h51, 1'b0);
        sbq.push_back('{r: 0, b: 8'h51});
        sbq.push_back('{r: 1, b: 8'h61});
        @(negedge clk);
        reset = 1'b0;
        viol = 0;
        for (int c = 0; c < 50 && busy_m; c++) begin
            @(negedge clk);
            if (grant != '0) viol++;
        end
        check("rmid_no_grant_while_busy", 32'(viol), 32'd0);
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (grant != '0) seen = 1;
        end
        check("rmid_first_grant", 32'(grant), 32'b0001);
        wait_drain("rmid");
        check("final_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
